// File: rtl/uart_core_cfg.sv
// Full-duplex UART with runtime parity / stop-bit selection and ready/valid on both sides.
// A shared baud tick drives 16x oversampling for the TX and RX state machines.
module uart_core_cfg #(
   parameter int D_BITS   = 8,
   parameter int SB_TICK  = 16,
   parameter int DIV_BITS = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DIV_BITS-1:0] cfg_divisor,
   input  logic [1:0]          cfg_parity,
   input  logic                cfg_two_stop,
   input  logic [D_BITS-1:0]   tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                tx,
   output logic                tx_busy,
   input  logic                rx,
   output logic [D_BITS-1:0]   rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                rx_parity_err,
   output logic                rx_frame_err,
   output logic                rx_overrun
);
   localparam int TW = $clog2(2*SB_TICK);
   localparam int BW = $clog2(D_BITS+1);
   localparam logic [TW-1:0] BIT_END   = TW'(SB_TICK-1);
   localparam logic [TW-1:0] STOP2_END = TW'(2*SB_TICK-1);
   localparam logic [TW-1:0] MID_START = TW'(SB_TICK/2-1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(D_BITS-1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- baud tick ----------------
   logic [DIV_BITS-1:0] r_baud_cnt;
   logic                w_tick;

   // >= keeps the counter bounded if the divisor is lowered while running
   assign w_tick = (r_baud_cnt >= cfg_divisor);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_baud_cnt <= '0;
      else if (w_tick) r_baud_cnt <= '0;
      else             r_baud_cnt <= r_baud_cnt + 1'b1;
   end

   // ---------------- transmitter ----------------
   state_t            r_tx_state, w_tx_state;
   logic [TW-1:0]     r_tx_tcnt, w_tx_tcnt;
   logic [BW-1:0]     r_tx_bcnt, w_tx_bcnt;
   logic [D_BITS-1:0] r_tx_shift, w_tx_shift;
   logic              r_tx_par, w_tx_par;
   logic              r_tx_par_en, w_tx_par_en;
   logic              r_tx_two, w_tx_two;
   logic              r_tx, w_tx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_state  <= S_IDLE;
         r_tx_tcnt   <= '0;
         r_tx_bcnt   <= '0;
         r_tx_shift  <= '0;
         r_tx_par    <= 1'b0;
         r_tx_par_en <= 1'b0;
         r_tx_two    <= 1'b0;
         r_tx        <= 1'b1;
      end else begin
         r_tx_state  <= w_tx_state;
         r_tx_tcnt   <= w_tx_tcnt;
         r_tx_bcnt   <= w_tx_bcnt;
         r_tx_shift  <= w_tx_shift;
         r_tx_par    <= w_tx_par;
         r_tx_par_en <= w_tx_par_en;
         r_tx_two    <= w_tx_two;
         r_tx        <= w_tx;
      end
   end

   always_comb begin
      w_tx_state  = r_tx_state;
      w_tx_tcnt   = r_tx_tcnt;
      w_tx_bcnt   = r_tx_bcnt;
      w_tx_shift  = r_tx_shift;
      w_tx_par    = r_tx_par;
      w_tx_par_en = r_tx_par_en;
      w_tx_two    = r_tx_two;
      w_tx        = 1'b1;
      case (r_tx_state)
         S_IDLE: if (tx_valid) begin
            w_tx_shift  = tx_data;
            w_tx_par    = (^tx_data) ^ (cfg_parity == 2'b10);
            w_tx_par_en = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            w_tx_two    = cfg_two_stop;
            w_tx_tcnt   = '0;
            w_tx_state  = S_START;
         end
         S_START: if (w_tick) begin
            if (r_tx_tcnt == BIT_END) begin
               w_tx_tcnt  = '0;
               w_tx_bcnt  = '0;
               w_tx_state = S_DATA;
            end else w_tx_tcnt = r_tx_tcnt + 1'b1;
         end
         S_DATA: if (w_tick) begin
            if (r_tx_tcnt == BIT_END) begin
               w_tx_tcnt  = '0;
               w_tx_shift = r_tx_shift >> 1;
               if (r_tx_bcnt == LAST_BIT) w_tx_state = r_tx_par_en ? S_PARITY : S_STOP;
               else                       w_tx_bcnt  = r_tx_bcnt + 1'b1;
            end else w_tx_tcnt = r_tx_tcnt + 1'b1;
         end
         S_PARITY: if (w_tick) begin
            if (r_tx_tcnt == BIT_END) begin
               w_tx_tcnt  = '0;
               w_tx_state = S_STOP;
            end else w_tx_tcnt = r_tx_tcnt + 1'b1;
         end
         S_STOP: if (w_tick) begin
            if (r_tx_tcnt == (r_tx_two ? STOP2_END : BIT_END)) begin
               w_tx_tcnt  = '0;
               w_tx_state = S_IDLE;
            end else w_tx_tcnt = r_tx_tcnt + 1'b1;
         end
         default: w_tx_state = S_IDLE;
      endcase
      // line level is decoded from the next state so the pin is a clean flop output
      case (w_tx_state)
         S_START:  w_tx = 1'b0;
         S_DATA:   w_tx = w_tx_shift[0];
         S_PARITY: w_tx = w_tx_par;
         default:  w_tx = 1'b1;
      endcase
   end

   assign tx       = r_tx;
   assign tx_ready = (r_tx_state == S_IDLE);
   assign tx_busy  = ~tx_ready;

   // ---------------- receiver ----------------
   logic              r_rx_s1, r_rx_s2;
   state_t            r_rx_state, w_rx_state;
   logic [TW-1:0]     r_rx_tcnt, w_rx_tcnt;
   logic [BW-1:0]     r_rx_bcnt, w_rx_bcnt;
   logic [D_BITS-1:0] r_rx_shift, w_rx_shift;
   logic              r_rx_par_en, w_rx_par_en;
   logic              r_rx_odd, w_rx_odd;
   logic              r_rx_perr, w_rx_perr;
   logic              w_rx_done, w_rx_ferr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_state  <= S_IDLE;
         r_rx_tcnt   <= '0;
         r_rx_bcnt   <= '0;
         r_rx_shift  <= '0;
         r_rx_par_en <= 1'b0;
         r_rx_odd    <= 1'b0;
         r_rx_perr   <= 1'b0;
      end else begin
         r_rx_s1     <= rx;
         r_rx_s2     <= r_rx_s1;
         r_rx_state  <= w_rx_state;
         r_rx_tcnt   <= w_rx_tcnt;
         r_rx_bcnt   <= w_rx_bcnt;
         r_rx_shift  <= w_rx_shift;
         r_rx_par_en <= w_rx_par_en;
         r_rx_odd    <= w_rx_odd;
         r_rx_perr   <= w_rx_perr;
      end
   end

   always_comb begin
      w_rx_state  = r_rx_state;
      w_rx_tcnt   = r_rx_tcnt;
      w_rx_bcnt   = r_rx_bcnt;
      w_rx_shift  = r_rx_shift;
      w_rx_par_en = r_rx_par_en;
      w_rx_odd    = r_rx_odd;
      w_rx_perr   = r_rx_perr;
      w_rx_done   = 1'b0;
      w_rx_ferr   = 1'b0;
      case (r_rx_state)
         S_IDLE: if (!r_rx_s2) begin
            w_rx_par_en = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            w_rx_odd    = (cfg_parity == 2'b10);
            w_rx_perr   = 1'b0;
            w_rx_tcnt   = '0;
            w_rx_state  = S_START;
         end
         S_START: if (w_tick) begin
            if (r_rx_tcnt == MID_START) begin
               w_rx_tcnt = '0;
               w_rx_bcnt = '0;
               // a start bit that is gone by mid-bit was a glitch
               w_rx_state = r_rx_s2 ? S_IDLE : S_DATA;
            end else w_rx_tcnt = r_rx_tcnt + 1'b1;
         end
         S_DATA: if (w_tick) begin
            if (r_rx_tcnt == BIT_END) begin
               w_rx_tcnt  = '0;
               w_rx_shift = {r_rx_s2, r_rx_shift[D_BITS-1:1]};
               if (r_rx_bcnt == LAST_BIT) w_rx_state = r_rx_par_en ? S_PARITY : S_STOP;
               else                       w_rx_bcnt  = r_rx_bcnt + 1'b1;
            end else w_rx_tcnt = r_rx_tcnt + 1'b1;
         end
         S_PARITY: if (w_tick) begin
            if (r_rx_tcnt == BIT_END) begin
               w_rx_tcnt  = '0;
               w_rx_perr  = r_rx_s2 ^ (^r_rx_shift) ^ r_rx_odd;
               w_rx_state = S_STOP;
            end else w_rx_tcnt = r_rx_tcnt + 1'b1;
         end
         S_STOP: if (w_tick) begin
            if (r_rx_tcnt == BIT_END) begin
               w_rx_tcnt  = '0;
               w_rx_done  = 1'b1;
               w_rx_ferr  = ~r_rx_s2;
               w_rx_state = S_IDLE;
            end else w_rx_tcnt = r_rx_tcnt + 1'b1;
         end
         default: w_rx_state = S_IDLE;
      endcase
   end

   // ---------------- RX output holding register ----------------
   logic              r_rx_valid, r_rx_perr_o, r_rx_ferr_o, r_rx_ovr;
   logic [D_BITS-1:0] r_rx_data;
   logic              w_take;

   assign w_take = r_rx_valid & rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_valid  <= 1'b0;
         r_rx_data   <= '0;
         r_rx_perr_o <= 1'b0;
         r_rx_ferr_o <= 1'b0;
         r_rx_ovr    <= 1'b0;
      end else if (w_rx_done && (!r_rx_valid || rx_ready)) begin
         r_rx_valid  <= 1'b1;
         r_rx_data   <= w_rx_shift;
         r_rx_perr_o <= r_rx_perr;
         r_rx_ferr_o <= w_rx_ferr;
         if (w_take) r_rx_ovr <= 1'b0;
      end else if (w_rx_done) begin
         r_rx_ovr <= 1'b1;
      end else if (w_take) begin
         r_rx_valid <= 1'b0;
         r_rx_ovr   <= 1'b0;
      end
   end

   assign rx_valid      = r_rx_valid;
   assign rx_data       = r_rx_data;
   assign rx_parity_err = r_rx_perr_o;
   assign rx_frame_err  = r_rx_ferr_o;
   assign rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Bench for uart_core_cfg: loopback and bench-driven frames checked against a
// bit-list model of the serial frame built from the data and config.
module tb_uart_core_cfg;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] cfg_divisor;
   logic [1:0]  cfg_parity;
   logic        cfg_two_stop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready, tx, tx_busy;
   logic        rx;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;
   logic        rx_parity_err, rx_frame_err, rx_overrun;
   logic        loop_en, drv_rx;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   assign rx = loop_en ? tx : drv_rx;

   uart_core_cfg #(.D_BITS(D), .SB_TICK(16), .DIV_BITS(11)) dut (
      .clk(clk), .reset(reset),
      .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity), .cfg_two_stop(cfg_two_stop),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
      .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic par_on(input logic [1:0] m);
      return (m == 2'b01) || (m == 2'b10);
   endfunction

   // even: number of ones in data+parity is even; odd: that count is odd
   function automatic logic par_bit(input logic [7:0] d, input logic [1:0] m);
      int ones;
      ones = 0;
      for (int i = 0; i < D; i++) ones += int'(d[i]);
      return (m == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   function automatic int bit_clk();
      return 16 * (int'(cfg_divisor) + 1);
   endfunction

   task automatic check_rx(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, d);
      chk("rx_parity_err", rx_parity_err, pe);
      chk("rx_frame_err", rx_frame_err, fe);
      chk("rx_overrun", rx_overrun, ov);
   endtask

   task automatic consume();
      @(negedge clk) rx_ready = 1'b1;
      @(negedge clk) rx_ready = 1'b0;
      chk("rx_valid_cleared", rx_valid, 0);
      chk("rx_overrun_cleared", rx_overrun, 0);
   endtask

   task automatic wait_tx_ready(input int lim);
      int i;
      i = 0;
      while (!tx_ready && i < lim) begin
         @(negedge clk);
         i++;
      end
      chk("tx_ready_wait", tx_ready, 1);
   endtask

   // Send one byte over the loopback, checking each bit at mid-bit, the frame
   // length, and the received byte. Config is scrambled mid-frame to confirm capture.
   task automatic send_lb(input logic [7:0] d);
      int B, nb, len, lo, hi, i, t0;
      logic [15:0] bits;
      logic [1:0] pm;
      logic two;
      B = bit_clk();
      pm = cfg_parity;
      two = cfg_two_stop;
      bits = '1;
      nb = 0;
      bits[nb++] = 1'b0;
      for (int k = 0; k < D; k++) bits[nb++] = d[k];
      if (par_on(pm)) bits[nb++] = par_bit(d, pm);
      bits[nb++] = 1'b1;
      if (two) bits[nb++] = 1'b1;
      wait_tx_ready(4 * B);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      t0 = cyc;
      chk("tx_start_edge", tx, 0);
      chk("tx_ready_drop", tx_ready, 0);
      chk("tx_busy", tx_busy, 1);
      repeat (6) @(negedge clk);
      cfg_parity   = 2'($urandom);
      cfg_two_stop = 1'($urandom);
      repeat (B/2 - 6) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         if (k > 0) repeat (B) @(negedge clk);
         chk($sformatf("tx_bit%0d", k), tx, bits[k]);
      end
      i = 0;
      while (!tx_ready && i < 2 * B) begin
         @(negedge clk);
         i++;
      end
      chk("tx_ready_end", tx_ready, 1);
      len = cyc - t0;
      hi  = nb * B;
      lo  = hi - int'(cfg_divisor);
      chk("frame_len_in_range", (len >= lo && len <= hi), 1);
      cfg_parity   = pm;
      cfg_two_stop = two;
      check_rx(d, 1'b0, 1'b0, 1'b0);
      consume();
   endtask

   // Drive a frame onto rx from the bench; optional parity flip and short low stop bit.
   task automatic drive_frame(input logic [7:0] d, input logic [1:0] pm,
                              input logic flip, input logic stop_low);
      int B;
      B = bit_clk();
      cfg_parity = pm;
      @(negedge clk) drv_rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int k = 0; k < D; k++) begin
         drv_rx = d[k];
         repeat (B) @(negedge clk);
      end
      if (par_on(pm)) begin
         drv_rx = par_bit(d, pm) ^ flip;
         repeat (B) @(negedge clk);
      end
      if (stop_low) begin
         drv_rx = 1'b0;
         repeat (B * 3 / 4) @(negedge clk);
         drv_rx = 1'b1;
         repeat (B - B * 3 / 4) @(negedge clk);
      end else begin
         drv_rx = 1'b1;
         repeat (B) @(negedge clk);
      end
      drv_rx = 1'b1;
      repeat (2 * B) @(negedge clk);
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] pm;
      logic fl, sl;
      reset = 1'b1;
      cfg_divisor = 11'd3;
      cfg_parity = 2'b00;
      cfg_two_stop = 1'b0;
      tx_data = '0;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      loop_en = 1'b1;
      drv_rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_tx_ready", tx_ready, 1);

      // 8N1, even, odd, 8N2 at divisor 3
      send_lb(8'hA5);
      cfg_parity = 2'b01; send_lb(8'hA5);
      cfg_parity = 2'b10; send_lb(8'hA5);
      cfg_parity = 2'b00; cfg_two_stop = 1'b1; send_lb(8'hA5);
      cfg_two_stop = 1'b0;

      // bench-driven error frames
      loop_en = 1'b0;
      drive_frame(8'hA5, 2'b10, 1'b1, 1'b0);
      check_rx(8'hA5, 1'b1, 1'b0, 1'b0);
      consume();
      drive_frame(8'h3C, 2'b00, 1'b0, 1'b1);
      check_rx(8'h3C, 1'b0, 1'b1, 1'b0);
      consume();
      drive_frame(8'h55, 2'b00, 1'b0, 1'b0);
      check_rx(8'h55, 1'b0, 1'b0, 1'b0);
      consume();

      // overrun
      drive_frame(8'h11, 2'b00, 1'b0, 1'b0);
      drive_frame(8'h22, 2'b00, 1'b0, 1'b0);
      check_rx(8'h11, 1'b0, 1'b0, 1'b1);
      consume();

      // start glitch shorter than half a bit
      @(negedge clk) drv_rx = 1'b0;
      repeat (20) @(negedge clk);
      drv_rx = 1'b1;
      repeat (3 * bit_clk()) @(negedge clk);
      chk("glitch_no_valid", rx_valid, 0);

      // reset in the middle of a TX frame
      loop_en = 1'b1;
      cfg_parity = 2'b00;
      wait_tx_ready(200);
      @(negedge clk);
      tx_data = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (3 * bit_clk()) @(negedge clk);
      chk("mid_frame_busy", tx_busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_tx_ready", tx_ready, 1);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("post_rst_tx", tx, 1);
      chk("post_rst_tx_ready", tx_ready, 1);
      chk("post_rst_rx_valid", rx_valid, 0);
      repeat (2 * bit_clk()) @(negedge clk);
      chk("post_rst_no_partial", rx_valid, 0);
      send_lb(8'h81);

      // randomized loopback frames
      for (int n = 0; n < 10; n++) begin
         cfg_divisor  = 11'($urandom_range(0, 3));
         cfg_parity   = 2'($urandom);
         cfg_two_stop = 1'($urandom);
         send_lb(8'($urandom));
      end

      // randomized driven frames with error injection
      loop_en = 1'b0;
      for (int n = 0; n < 6; n++) begin
         cfg_divisor = 11'($urandom_range(0, 3));
         d  = 8'($urandom);
         pm = 2'($urandom);
         fl = 1'($urandom);
         sl = 1'($urandom);
         drive_frame(d, pm, fl, sl);
         check_rx(d, fl & par_on(pm), sl, 1'b0);
         consume();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
